// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control FSM and its datapath interface.
package ctrl_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_JUMP,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [2:0] F3_LW   = 3'b010;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    // Registered control word presented to the datapath.
    typedef struct packed {
        logic             imem_req;
        logic             dmem_req;
        logic             reg_write;
        logic             retire;
        logic             illegal;
        alu_op_e          alu;
        wb_sel_e          wb;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } ctl_t;

    // Sign-extended J-type immediate.
    function automatic logic [XLEN_W-1:0] jal_imm(input logic [XLEN_W-1:0] ir);
        return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch and data-read handshake between the controller and memory side.
interface multicycle_ctrl_if;

    logic                          imem_req;
    logic [ctrl_pkg::XLEN_W-1:0]   imem_addr;
    logic                          imem_valid;
    logic [ctrl_pkg::XLEN_W-1:0]   imem_rdata;
    logic                          dmem_req;
    logic                          dmem_valid;

    modport master (
        output imem_req, imem_addr, dmem_req,
        input  imem_valid, imem_rdata, dmem_valid
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req,
        output imem_valid, imem_rdata, dmem_valid
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps R-type funct3/funct7 to an ALU operation; flags encodings the ALU cannot execute.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    alu_op,
    output logic       bad
);

    always_comb begin
        alu_op = ALU_ADD;
        bad    = 1'b0;
        unique case (funct7)
            7'b0000000: begin
                unique case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    default: bad = 1'b1;
                endcase
            end
            7'b0100000: begin
                unique case (funct3)
                    3'b000:  alu_op = ALU_SUB;
                    3'b101:  alu_op = ALU_SRA;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC|MEM|JUMP sequencer for the register-file/ALU datapath.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_if.master    bus,
    output logic [XLEN-1:0]      pc,
    output logic                 reg_write,
    output logic [3:0]           alu_control,
    output logic [REG_W-1:0]     rs1,
    output logic [REG_W-1:0]     rs2,
    output logic [REG_W-1:0]     rd,
    output logic [1:0]           mem_to_reg,
    output logic                 retire,
    output logic                 illegal
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    ctl_t            ctl_q, ctl_d;

    alu_op_e         dec_op;
    logic            dec_bad;
    logic [XLEN-1:0] jal_target;
    logic            jal_misaligned;
    logic            load_ok;
    logic            rd_nz;
    logic            mem_done;

    // IR only changes on leaving FETCH, so ir_d equals ir_q in every decode-dependent state.
    alu_decoder u_alu_decoder (
        .funct3 (ir_d[14:12]),
        .funct7 (ir_d[31:25]),
        .alu_op (dec_op),
        .bad    (dec_bad)
    );

    assign jal_target     = pc_q + jal_imm(ir_d);
    assign jal_misaligned = |jal_target[1:0];
    assign load_ok        = (ir_d[14:12] == F3_LW) && (ir_d[31:20] == 12'd0);
    assign rd_nz          = |ir_d[11:7];
    assign mem_done       = (state_q == ST_MEM) && bus.dmem_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= XLEN'(RESET_PC);
            ir_q    <= '0;
            ctl_q   <= '{alu: ALU_ADD, wb: WB_ALU, default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ctl_q   <= ctl_d;
        end
    end

    // Next state, IR and PC. Fetch completes only once the registered request is visible.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            ST_FETCH: begin
                if (bus.imem_valid && ctl_q.imem_req) begin
                    ir_d    = bus.imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ir_q[6:0] == OP_R)                   state_d = ST_EXEC;
                else if (ir_q[6:0] == OP_LOAD && load_ok) state_d = ST_MEM;
                else if (ir_q[6:0] == OP_JAL)            state_d = ST_JUMP;
                else                                     state_d = ST_TRAP;
            end
            ST_EXEC: begin
                if (dec_bad) begin
                    state_d = ST_TRAP;
                end else begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (bus.dmem_valid) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = ST_FETCH;
                end
            end
            ST_JUMP: begin
                if (jal_misaligned) begin
                    state_d = ST_TRAP;
                end else begin
                    pc_d    = jal_target;
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    // Control word for the upcoming state, registered so outputs are glitch-free.
    always_comb begin
        ctl_d     = '0;
        ctl_d.alu = ALU_ADD;
        ctl_d.wb  = WB_ALU;
        if (state_d != ST_FETCH) begin
            ctl_d.rs1 = ir_d[19:15];
            ctl_d.rs2 = ir_d[24:20];
            ctl_d.rd  = ir_d[11:7];
        end
        unique case (state_d)
            ST_FETCH: ctl_d.imem_req = 1'b1;
            ST_EXEC: begin
                ctl_d.alu       = dec_op;
                ctl_d.reg_write = !dec_bad && rd_nz;
                ctl_d.retire    = !dec_bad;
            end
            ST_MEM: begin
                ctl_d.dmem_req = 1'b1;
                ctl_d.rs2      = '0;
                ctl_d.wb       = WB_MEM;
            end
            ST_JUMP: begin
                ctl_d.wb        = WB_PC4;
                ctl_d.reg_write = !jal_misaligned && rd_nz;
                ctl_d.retire    = !jal_misaligned;
            end
            ST_TRAP: ctl_d.illegal = 1'b1;
            default: ctl_d.illegal = 1'b0;
        endcase
    end

    assign bus.imem_req  = ctl_q.imem_req;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = ctl_q.dmem_req;

    assign pc          = pc_q;
    assign alu_control = ctl_q.alu;
    assign mem_to_reg  = ctl_q.wb;
    assign rs1         = ctl_q.rs1;
    assign rs2         = ctl_q.rs2;
    assign rd          = ctl_q.rd;
    assign illegal     = ctl_q.illegal;
    // Load completion is the only place data-side valid reaches an output directly.
    assign reg_write   = ctl_q.reg_write | (mem_done && (|ir_q[11:7]));
    assign retire      = ctl_q.retire | mem_done;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: R-type, LW, JAL, traps, pc wrap, async reset.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        reg_write;
    logic [3:0]  alu_control;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  mem_to_reg;
    logic        retire;
    logic        illegal;

    int tests;
    int fails;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .pc          (pc),
        .reg_write   (reg_write),
        .alu_control (alu_control),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .mem_to_reg  (mem_to_reg),
        .retire      (retire),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.imem_valid = 1'b0;
        bus.dmem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    // Leaves the bench sampling the DECODE cycle.
    task automatic do_fetch(input logic [31:0] instr, input int waits, input logic [31:0] exp_pc);
        repeat (waits) step();
        tests++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_pc}) begin
            fails++;
            $display("FAIL fetch_req: got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, exp_pc);
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = instr;
        step();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tests++;
        if (bus.imem_req !== 1'b0) begin
            fails++;
            $display("FAIL decode_req: got %b exp 0", bus.imem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dmem_valid = 1'b0;
        #12;
        tests++;
        if ({bus.imem_req, bus.dmem_req, reg_write, retire, illegal, pc, alu_control, mem_to_reg, rs1, rs2, rd}
            !== {5'b0, 32'h0, 4'b0010, 2'b00, 15'd0}) begin
            fails++;
            $display("FAIL reset_state: got req=%b dreq=%b we=%b ret=%b ill=%b pc=%h alu=%b wb=%b rs=%0d/%0d/%0d",
                     bus.imem_req, bus.dmem_req, reg_write, retire, illegal, pc, alu_control, mem_to_reg, rs1, rs2, rd);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_rtype(input string name, input logic [31:0] instr, input int waits,
                              input logic [31:0] exp_pc, input logic [3:0] exp_alu,
                              input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] ed,
                              input logic exp_we);
        int nret;
        do_fetch(instr, waits, exp_pc);
        nret = int'(retire);
        step();
        nret += int'(retire);
        tests++;
        if ({alu_control, reg_write, mem_to_reg, rs1, rs2, rd, pc} !== {exp_alu, exp_we, 2'b00, e1, e2, ed, exp_pc}) begin
            fails++;
            $display("FAIL %s_exec: got alu=%b we=%b wb=%b rs=%0d/%0d/%0d pc=%h exp alu=%b we=%b wb=00 rs=%0d/%0d/%0d pc=%h",
                     name, alu_control, reg_write, mem_to_reg, rs1, rs2, rd, pc, exp_alu, exp_we, e1, e2, ed, exp_pc);
        end
        step();
        nret += int'(retire);
        tests++;
        if (nret !== 1) begin
            fails++;
            $display("FAIL %s_retire_count: got %0d exp 1", name, nret);
        end
        tests++;
        if ({pc, rs1, rd, reg_write} !== {exp_pc + 32'd4, 5'd0, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL %s_next: got pc=%h rs1=%0d rd=%0d we=%b exp pc=%h rs1=0 rd=0 we=0",
                     name, pc, rs1, rd, reg_write, exp_pc + 32'd4);
        end
    endtask

    task automatic test_load();
        int dreq_cycles;
        dreq_cycles = 0;
        do_fetch(32'h0000_A283, 0, 32'h8);
        for (int c = 0; c < 2; c++) begin
            step();
            dreq_cycles += int'(bus.dmem_req);
            tests++;
            if ({rs1, rs2, alu_control, reg_write, retire} !== {5'd1, 5'd0, 4'b0010, 2'b00}) begin
                fails++;
                $display("FAIL lw_wait%0d: got rs1=%0d rs2=%0d alu=%b we=%b ret=%b exp rs1=1 rs2=0 alu=0010 we=0 ret=0",
                         c, rs1, rs2, alu_control, reg_write, retire);
            end
        end
        step();
        bus.dmem_valid = 1'b1;
        #1;
        dreq_cycles += int'(bus.dmem_req);
        tests++;
        if ({reg_write, mem_to_reg, retire, rd} !== {1'b1, 2'b01, 1'b1, 5'd5}) begin
            fails++;
            $display("FAIL lw_done: got we=%b wb=%b ret=%b rd=%0d exp we=1 wb=01 ret=1 rd=5", reg_write, mem_to_reg, retire, rd);
        end
        step();
        bus.dmem_valid = 1'b0;
        tests++;
        if (dreq_cycles !== 3) begin
            fails++;
            $display("FAIL lw_dreq_cycles: got %0d exp 3", dreq_cycles);
        end
        tests++;
        if ({bus.dmem_req, reg_write, pc} !== {2'b00, 32'hC}) begin
            fails++;
            $display("FAIL lw_next: got dreq=%b we=%b pc=%h exp dreq=0 we=0 pc=0000000c", bus.dmem_req, reg_write, pc);
        end
    endtask

    task automatic test_jal();
        do_fetch(32'h0080_00EF, 0, 32'h10);
        step();
        tests++;
        if ({mem_to_reg, reg_write, retire, rd, pc} !== {2'b10, 1'b1, 1'b1, 5'd1, 32'h10}) begin
            fails++;
            $display("FAIL jal_jump: got wb=%b we=%b ret=%b rd=%0d pc=%h exp wb=10 we=1 ret=1 rd=1 pc=00000010",
                     mem_to_reg, reg_write, retire, rd, pc);
        end
        step();
        tests++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h18}) begin
            fails++;
            $display("FAIL jal_target: got req=%b addr=%h exp req=1 addr=00000018", bus.imem_req, bus.imem_addr);
        end
    endtask

    // Samples the first TRAP cycle then ten more with everything frozen.
    task automatic check_trap_hold(input string name, input logic [31:0] exp_pc);
        for (int c = 0; c < 11; c++) begin
            tests++;
            if ({illegal, reg_write, retire, bus.imem_req, bus.dmem_req, pc} !== {5'b10000, exp_pc}) begin
                fails++;
                $display("FAIL %s_hold%0d: got ill=%b we=%b ret=%b req=%b dreq=%b pc=%h exp ill=1 others 0 pc=%h",
                         name, c, illegal, reg_write, retire, bus.imem_req, bus.dmem_req, pc, exp_pc);
            end
            step();
        end
    endtask

    task automatic test_trap();
        do_fetch(32'h0000_0013, 0, 32'h1C);
        step();
        check_trap_hold("addi", 32'h1C);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (illegal !== 1'b0) begin
            fails++;
            $display("FAIL trap_async_clear: got %b exp 0", illegal);
        end
        apply_reset();
        do_fetch(32'h0040_A283, 0, 32'h0);
        step();
        check_trap_hold("lw_imm4", 32'h0);

        apply_reset();
        do_fetch(32'h4020_91B3, 0, 32'h0);
        step();
        tests++;
        if ({reg_write, retire, illegal} !== 3'b000) begin
            fails++;
            $display("FAIL bad_rtype_exec: got we=%b ret=%b ill=%b exp 000", reg_write, retire, illegal);
        end
        step();
        check_trap_hold("bad_rtype", 32'h0);

        apply_reset();
        do_fetch(32'h0020_00EF, 0, 32'h0);
        step();
        tests++;
        if ({reg_write, retire, mem_to_reg, pc} !== {2'b00, 2'b10, 32'h0}) begin
            fails++;
            $display("FAIL jal_misaligned: got we=%b ret=%b wb=%b pc=%h exp we=0 ret=0 wb=10 pc=0", reg_write, retire, mem_to_reg, pc);
        end
        step();
        check_trap_hold("jal_mis", 32'h0);
    endtask

    task automatic test_wrap();
        apply_reset();
        do_fetch(32'hFFDF_F06F, 0, 32'h0);
        step();
        tests++;
        if ({reg_write, retire} !== 2'b01) begin
            fails++;
            $display("FAIL wrap_jal_x0: got we=%b ret=%b exp we=0 ret=1", reg_write, retire);
        end
        step();
        test_rtype("wrap_add", 32'h0020_81B3, 0, 32'hFFFF_FFFC, 4'b0010, 5'd1, 5'd2, 5'd3, 1'b1);
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        do_fetch(32'h0000_A283, 0, 32'h0);
        step();
        step();
        tests++;
        if (bus.dmem_req !== 1'b1) begin
            fails++;
            $display("FAIL midmem_req: got %b exp 1", bus.dmem_req);
        end
        #3;
        bus.dmem_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.dmem_req, reg_write, retire, pc} !== {3'b000, 32'h0}) begin
            fails++;
            $display("FAIL midmem_reset: got dreq=%b we=%b ret=%b pc=%h exp 0 0 0 0", bus.dmem_req, reg_write, retire, pc);
        end
        bus.dmem_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        tests++;
        if ({bus.imem_req, bus.imem_addr, pc} !== {1'b1, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL midmem_after: got req=%b addr=%h pc=%h exp req=1 addr=0 pc=0", bus.imem_req, bus.imem_addr, pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_rtype("add", 32'h0020_81B3, 3, 32'h0, 4'b0010, 5'd1, 5'd2, 5'd3, 1'b1);
        test_rtype("sub", 32'h4020_8233, 0, 32'h4, 4'b0110, 5'd1, 5'd2, 5'd4, 1'b1);
        test_load();
        test_rtype("xor", 32'h0020_C1B3, 1, 32'hC, 4'b0011, 5'd1, 5'd2, 5'd3, 1'b1);
        test_jal();
        test_rtype("add_x0", 32'h0020_8033, 0, 32'h18, 4'b0010, 5'd1, 5'd2, 5'd0, 1'b0);
        test_trap();
        test_wrap();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
